ahb_regfile_slave: RTL and testbench
====================================

Name: ahb_regfile_slave

Overview:
- Parametrised AHB-Lite register-file slave, successor to the fixed 8-entry slave.
- Generalised depth/width, configurable wait states, byte/halfword/word writes via HSIZE, and a proper two-cycle ERROR response.
- Sits behind the address decoder on the AHB interconnect, selected by HSELx, and returns HREADYOUT/HRESP/HRDATA to the slave mux.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width; 32 or 64.
- DEPTH, 16, number of DATA_WIDTH registers; power of 2, 2..256.
- WAIT_STATES, 0, extra data-phase cycles with HREADYOUT low for OKAY transfers; 0..7.

Ports:
- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  synchronous active-high reset
- HSELx  in  1  slave select
- HADDR  in  ADDR_WIDTH  address (byte)
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type; accepted, not decoded
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HREADY  in  1  bus ready (previous transfer complete)
- HWDATA  in  DATA_WIDTH  write data (data phase)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_WIDTH  read data

Behaviour:
- Reset (HRESET=1 at a HCLK edge):
  - all registers cleared to 0; state = D_IDLE
  - HREADYOUT=1, HRESP=0, HRDATA=0
  - reset mid-transfer aborts the transfer with no memory update.
- Address-phase capture: only when HSELx & HREADY & HTRANS[1].
  - Captured fields: word index = HADDR[log2(DATA_WIDTH/8) +: log2(DEPTH)], byte offset, HSIZE, HWRITE.
  - IDLE/BUSY or unselected transfers → zero-wait OKAY; no capture.
- Error check at capture:
  - word index field from HADDR bits above the word offset ≥ DEPTH (any upper address bit set within the decoded window), or
  - HSIZE > log2(DATA_WIDTH/8), or
  - address not aligned to HSIZE.
- Data-phase FSM states: D_IDLE, D_WAIT, D_ERR1, D_ERR2.
  - D_IDLE:
    - valid OK capture with WAIT_STATES=0 → data phase completes next cycle (state D_WAIT with count 0);
    - error capture → D_ERR1.
  - D_WAIT:
    - counter loads WAIT_STATES at capture and decrements each cycle;
    - HREADYOUT=0 while count≠0;
    - at count=0, HREADYOUT=1, HRESP=0 and the transfer completes; back-to-back capture allowed in the same cycle.
  - D_ERR1: HREADYOUT=0, HRESP=1; → D_ERR2.
  - D_ERR2: HREADYOUT=1, HRESP=1; a new capture is allowed, else → D_IDLE.
- Write commit:
  - on the completing data-phase cycle (HREADYOUT=1, OKAY) only;
  - byte lanes enabled per HSIZE and byte offset (little-endian); other lanes unchanged.
- Read:
  - HRDATA = full register at the captured index during the completing cycle;
  - HRDATA = 0 in all other cycles and on ERROR.
- Read in the cycle after a write to the same address returns the new data (the write commits before the read data phase).
- Erroring transfers never modify memory.
- HBURST is ignored; SEQ is treated identically to NONSEQ.

Optional Feature:
- Macro: AHB_REGFILE_LOCK_EN.
- Defined:
  - register DEPTH-1 bit0 is a write-lock;
  - while set, writes to indices 0..DEPTH-2 take the two-cycle ERROR response with no update;
  - index DEPTH-1 itself stays writable, so clearing bit0 unlocks;
  - reads are unaffected.
- Undefined: no lock; register DEPTH-1 is an ordinary register.

Test Plan:
- Reset, then word write 0xDEADBEEF to HADDR 0x0C, then read 0x0C (WAIT_STATES=0) → single-cycle OKAY each; read returns 0xDEADBEEF.
- WAIT_STATES=2: read of 0x04 → HREADYOUT low for exactly 2 cycles, then high with OKAY and data.
- Byte write 0xAA to 0x0D over a preset 0x11223344 at 0x0C → readback 0x1122AA44.
- DEPTH=16, write to 0x40 (index 16) → HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; register 0 unchanged.
- Halfword write to 0x03 (misaligned) → two-cycle ERROR; back-to-back write 0x55 to 0x00 in the ERR2 cycle → OKAY, reads 0x55.
- With AHB_REGFILE_LOCK_EN: write 1 to index DEPTH-1, write to 0x00 → ERROR; write 0 to index DEPTH-1, then write to 0x00 → OKAY.

Source files
------------

// File: rtl/ahb_regfile_slave.sv
// Parametrised AHB-Lite register-file slave with wait states, byte-lane writes and two-cycle ERROR.
// Optional write-lock on register DEPTH-1 bit0 is enabled by defining AHB_REGFILE_LOCK_EN.
`timescale 1ns/1ps
module ahb_regfile_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELx,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int               BYTES    = DATA_WIDTH / 8;
  localparam int               OFF_W    = $clog2(BYTES);
  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [2:0]       MAX_SIZE = 3'(OFF_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_ERR1, D_ERR2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BYTES-1:0]      r_be;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic             w_capture;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic [BYTES-1:0] w_be;
  logic             w_upper;
  logic             w_misalign;
  logic             w_lock_err;
  logic             w_err;
  logic             w_done;
  logic             w_commit;
  logic             w_unused;

  assign w_capture = HSELx & HREADY & HTRANS[1];
  assign w_idx     = HADDR[OFF_W +: IDX_W];
  assign w_off     = HADDR[OFF_W-1:0];
  assign w_upper   = (HADDR >> (OFF_W + IDX_W)) != '0;
  assign w_done    = (r_state == D_WAIT) && (r_cnt == 3'd0);
  assign w_commit  = w_done & r_write;
  assign w_unused  = &{1'b0, HBURST, HTRANS[0]};

  // Address-phase decode: lane enables, alignment and error classification.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_be       = '0;
    w_lock_err = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if (b >= int'(w_off) && b < int'(w_off) + (1 << HSIZE)) w_be[b] = 1'b1;
    end
    w_misalign = |(w_off & OFF_W'((1 << HSIZE) - 1));
`ifdef AHB_REGFILE_LOCK_EN
    // Lock bit seen through any write to DEPTH-1 that commits this same cycle.
    if (HWRITE && w_idx != LAST_IDX) begin
      if (w_commit && r_idx == LAST_IDX && r_be[0]) w_lock_err = HWDATA[0];
      else                                          w_lock_err = r_mem[DEPTH-1][0];
    end
`endif
    w_err = w_upper | (HSIZE > MAX_SIZE) | w_misalign | w_lock_err;
  end

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (HRESET) begin
      r_state <= D_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_be    <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_cnt   <= 3'(WAIT_STATES);
        r_idx   <= w_idx;
        r_be    <= w_be;
        r_write <= HWRITE;
      end else if (r_state == D_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // NOTE: the register file is a flop array, so it is cleared by reset; a RAM macro could not be.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_capture) begin
      w_next = w_err ? D_ERR1 : D_WAIT;
    end else begin
      case (r_state)
        D_WAIT:  if (r_cnt == 3'd0) w_next = D_IDLE;
        D_ERR1:  w_next = D_ERR2;
        D_ERR2:  w_next = D_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (r_state)
      D_WAIT: begin
        HREADYOUT = (r_cnt == 3'd0);
        if (w_done && !r_write) HRDATA = r_mem[r_idx];
      end
      D_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      D_ERR2:  HRESP = 1'b1;
      default: HREADYOUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ahb_regfile_slave.sv
// Directed bench for ahb_regfile_slave: one instance with WAIT_STATES=0, one with WAIT_STATES=2.
// Lock-feature vectors are included when AHB_REGFILE_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_ahb_regfile_slave;

  logic        clk = 1'b0;
  logic        hreset, hsel, use2, hwrite;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic        sel0, sel2;
  logic        hro0, hro2, hresp0, hresp2;
  logic [31:0] hrd0, hrd2;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign sel0      = hsel & ~use2;
  assign sel2      = hsel & use2;
  assign hreadyout = use2 ? hro2   : hro0;
  assign hresp     = use2 ? hresp2 : hresp0;
  assign hrdata    = use2 ? hrd2   : hrd0;

  ahb_regfile_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset), .HSELx(sel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hro0), .HWDATA(hwdata),
    .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrd0)
  );

  ahb_regfile_slave #(.WAIT_STATES(2)) u_dut2 (
    .HCLK(clk), .HRESET(hreset), .HSELx(sel2), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hro2), .HWDATA(hwdata),
    .HREADYOUT(hro2), .HRESP(hresp2), .HRDATA(hrd2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  // Complete OKAY transfer expecting exactly ws low-HREADYOUT cycles before completion.
  task automatic xfer_ok(input string tag, input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [31:0] wd, input int ws, input logic [31:0] rexp);
    addr_phase(a, w, s);
    tick();
    bus_idle();
    hwdata = wd;
    for (int i = 0; i < ws; i++) begin
      @(negedge clk);
      check({tag, " wait ready"}, {31'd0, hreadyout}, 32'd0);
      tick();
    end
    @(negedge clk);
    check({tag, " ready"}, {31'd0, hreadyout}, 32'd1);
    check({tag, " resp"},  {31'd0, hresp},     32'd0);
    check({tag, " rdata"}, hrdata, w ? 32'd0 : rexp);
    tick();
  endtask

  task automatic xfer_err(input string tag, input logic [31:0] a, input logic w, input logic [2:0] s,
                          input logic [31:0] wd);
    addr_phase(a, w, s);
    tick();
    bus_idle();
    hwdata = wd;
    @(negedge clk);
    check({tag, " err1 ready"}, {31'd0, hreadyout}, 32'd0);
    check({tag, " err1 resp"},  {31'd0, hresp},     32'd1);
    tick();
    @(negedge clk);
    check({tag, " err2 ready"}, {31'd0, hreadyout}, 32'd1);
    check({tag, " err2 resp"},  {31'd0, hresp},     32'd1);
    check({tag, " err2 rdata"}, hrdata, 32'd0);
    tick();
  endtask

  initial begin
    hreset = 1'b1; use2 = 1'b0; hburst = 3'd0; hwdata = '0;
    haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    bus_idle();
    repeat (3) tick();
    hreset = 1'b0;
    @(negedge clk);
    check("rst ready0", {31'd0, hro0}, 32'd1);
    check("rst resp0",  {31'd0, hresp0}, 32'd0);
    check("rst rdata0", hrd0, 32'd0);
    check("rst ready2", {31'd0, hro2}, 32'd1);
    check("rst rdata2", hrd2, 32'd0);
    tick();

    // Single-cycle word write and readback.
    xfer_ok("wr 0x0C", 32'h0C, 1'b1, 3'd2, 32'hDEADBEEF, 0, 32'h0);
    xfer_ok("rd 0x0C", 32'h0C, 1'b0, 3'd2, 32'h0, 0, 32'hDEADBEEF);

    // Byte write into lane 1.
    xfer_ok("preset 0x0C", 32'h0C, 1'b1, 3'd2, 32'h11223344, 0, 32'h0);
    xfer_ok("byte 0x0D",   32'h0D, 1'b1, 3'd0, 32'h0000AA00, 0, 32'h0);
    xfer_ok("rd byte",     32'h0C, 1'b0, 3'd2, 32'h0, 0, 32'h1122AA44);

    // Out-of-range index must not alias onto register 0.
    xfer_ok("preset 0x00", 32'h00, 1'b1, 3'd2, 32'h12345678, 0, 32'h0);
    xfer_err("oor 0x40",   32'h40, 1'b1, 3'd2, 32'hFFFFFFFF);
    xfer_ok("rd 0x00",     32'h00, 1'b0, 3'd2, 32'h0, 0, 32'h12345678);

    // Misaligned halfword, then back-to-back capture during ERR2.
    addr_phase(32'h03, 1'b1, 3'd1);
    tick();
    bus_idle();
    hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("mis err1 ready", {31'd0, hreadyout}, 32'd0);
    check("mis err1 resp",  {31'd0, hresp},     32'd1);
    tick();
    addr_phase(32'h00, 1'b1, 3'd2);
    @(negedge clk);
    check("mis err2 ready", {31'd0, hreadyout}, 32'd1);
    check("mis err2 resp",  {31'd0, hresp},     32'd1);
    tick();
    bus_idle();
    hwdata = 32'h55;
    @(negedge clk);
    check("b2b wr ready", {31'd0, hreadyout}, 32'd1);
    check("b2b wr resp",  {31'd0, hresp},     32'd0);
    tick();
    xfer_ok("rd b2b", 32'h00, 1'b0, 3'd2, 32'h0, 0, 32'h55);

    // Aligned halfword into upper lanes; oversize transfer errors.
    xfer_ok("half 0x02",  32'h02, 1'b1, 3'd1, 32'hBEEF0000, 0, 32'h0);
    xfer_ok("rd half",    32'h00, 1'b0, 3'd2, 32'h0, 0, 32'hBEEF0055);
    xfer_err("size 3",    32'h00, 1'b1, 3'd3, 32'h0);
    xfer_ok("rd size",    32'h00, 1'b0, 3'd2, 32'h0, 0, 32'hBEEF0055);

    // Pipelined write then read of the same word.
    addr_phase(32'h08, 1'b1, 3'd2);
    tick();
    addr_phase(32'h08, 1'b0, 3'd2);
    hwdata = 32'hA5A55A5A;
    @(negedge clk);
    check("raw wr ready", {31'd0, hreadyout}, 32'd1);
    tick();
    bus_idle();
    @(negedge clk);
    check("raw rd rdata", hrdata, 32'hA5A55A5A);
    tick();

    // Unselected NONSEQ and selected BUSY must not capture.
    hsel = 1'b0; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hsel = 1'b1; htrans = 2'b01;
    hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("nosel ready", {31'd0, hreadyout}, 32'd1);
    tick();
    bus_idle();
    @(negedge clk);
    check("busy ready", {31'd0, hreadyout}, 32'd1);
    check("busy resp",  {31'd0, hresp},     32'd0);
    tick();
    xfer_ok("rd nocap", 32'h08, 1'b0, 3'd2, 32'h0, 0, 32'hA5A55A5A);

`ifdef AHB_REGFILE_LOCK_EN
    xfer_ok("lock set",   32'h3C, 1'b1, 3'd2, 32'h1, 0, 32'h0);
    xfer_err("locked wr", 32'h00, 1'b1, 3'd2, 32'h77);
    xfer_ok("locked rd",  32'h00, 1'b0, 3'd2, 32'h0, 0, 32'hBEEF0055);
    xfer_ok("lock clr",   32'h3C, 1'b1, 3'd2, 32'h0, 0, 32'h0);
    xfer_ok("unlock wr",  32'h00, 1'b1, 3'd2, 32'h77, 0, 32'h0);
    xfer_ok("unlock rd",  32'h00, 1'b0, 3'd2, 32'h0, 0, 32'h77);
`else
    xfer_ok("plain last wr", 32'h3C, 1'b1, 3'd2, 32'h1, 0, 32'h0);
    xfer_ok("plain wr 0",    32'h00, 1'b1, 3'd2, 32'h77, 0, 32'h0);
    xfer_ok("plain rd 0",    32'h00, 1'b0, 3'd2, 32'h0, 0, 32'h77);
`endif

    // Two-wait-state instance.
    use2 = 1'b1;
    xfer_ok("ws2 wr 0x04", 32'h04, 1'b1, 3'd2, 32'hCAFEF00D, 2, 32'h0);
    xfer_ok("ws2 rd 0x04", 32'h04, 1'b0, 3'd2, 32'h0, 2, 32'hCAFEF00D);

    // Reset during a wait state aborts the transfer.
    addr_phase(32'h04, 1'b1, 3'd2);
    tick();
    bus_idle();
    hwdata = 32'h12345678;
    @(negedge clk);
    check("rstmid wait", {31'd0, hreadyout}, 32'd0);
    tick();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    @(negedge clk);
    check("rstmid ready", {31'd0, hreadyout}, 32'd1);
    check("rstmid resp",  {31'd0, hresp},     32'd0);
    tick();
    xfer_ok("rstmid rd", 32'h04, 1'b0, 3'd2, 32'h0, 2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
